// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants for the SimMIPS execute-stage ALU.
// The bit positions of the one-hot alu_control vector live here, so the
// decode stage and the ALU always agree on which bit selects which operation.
// No ports; import with "import alu_pkg::*;".
package alu_pkg;

    localparam int ALU_CTRL_W = 12;
    localparam int ALU_DATA_W = 32;

    // One-hot select bit indices, MSB first.
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;
    typedef logic [ALU_DATA_W-1:0] alu_data_t;

endpackage

// File: rtl/mips_alu_if.sv
// mips_alu_if
// Bundles the decode-to-ALU operand/select bus and the ALU result.
//   alu_control : one-hot operation select (decode -> ALU)
//   alu_src1    : operand A, shift amount in [4:0] (decode -> ALU)
//   alu_src2    : operand B, shift/LUI source (decode -> ALU)
//   alu_result  : registered result (ALU -> downstream)
//   overflow    : registered signed-overflow flag, only when ALU_OVERFLOW_EN
//                 is defined
// Modports: master = the side driving operands (decode / testbench),
//           slave  = the ALU.
interface mips_alu_if;
    import alu_pkg::*;

    alu_ctrl_t alu_control;
    alu_data_t alu_src1;
    alu_data_t alu_src2;
    alu_data_t alu_result;
`ifdef ALU_OVERFLOW_EN
    logic      overflow;

    modport master (output alu_control, output alu_src1, output alu_src2,
                    input alu_result, input overflow);
    modport slave  (input alu_control, input alu_src1, input alu_src2,
                    output alu_result, output overflow);
`else
    modport master (output alu_control, output alu_src1, output alu_src2,
                    input alu_result);
    modport slave  (input alu_control, input alu_src1, input alu_src2,
                    output alu_result);
`endif

endinterface

// File: rtl/alu_adder.sv
// alu_adder
// Single 32-bit adder shared by add, sub, slt and sltu.
// Computes a + (invert_b ? ~b : b) + cin.
//   a, b     : 32-bit operands
//   invert_b : complement b before adding (subtract path)
//   cin      : carry in (1 together with invert_b gives a - b)
//   sum      : 32-bit sum
//   cout     : carry out of bit 31
//   ovf      : signed overflow of the addition actually performed
module alu_adder
    import alu_pkg::*;
(
    input  alu_data_t a,
    input  alu_data_t b,
    input  logic      invert_b,
    input  logic      cin,
    output alu_data_t sum,
    output logic      cout,
    output logic      ovf
);

    alu_data_t b_eff;

    // Overflow happens when both addends share a sign and the sum's sign
    // differs from it. With b inverted this is exactly the subtract rule:
    // operand signs differ and the result sign differs from a.
    always_comb begin
        b_eff       = invert_b ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{ALU_DATA_W{1'b0}}, cin};
        ovf         = (a[ALU_DATA_W-1] == b_eff[ALU_DATA_W-1]) &&
                      (sum[ALU_DATA_W-1] != a[ALU_DATA_W-1]);
    end

endmodule

// File: rtl/mips_alu.sv
// mips_alu
// Registered 32-bit integer ALU for the SimMIPS execute stage. Inputs sampled
// at a rising edge produce alu_result right after that edge (latency 1, one
// operation per cycle, no handshake).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears the registered outputs
//   bus   : mips_alu_if.slave (alu_control, alu_src1, alu_src2 in;
//           alu_result and optionally overflow out)
// Build option: define ALU_OVERFLOW_EN to add the registered overflow flag.
module mips_alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mips_alu_if.slave  bus
);

    alu_ctrl_t ctrl;
    alu_data_t op_a;
    alu_data_t op_b;
    logic [4:0] shamt;

    logic      use_sub;
    alu_data_t add_sum;
    logic      add_cout;
    logic      add_ovf;
    logic      slt_bit;
    logic      sltu_bit;
    alu_data_t result_next;
    alu_data_t result_q;

    assign ctrl  = bus.alu_control;
    assign op_a  = bus.alu_src1;
    assign op_b  = bus.alu_src2;
    assign shamt = op_a[4:0];

    // sub, slt and sltu all need a - b from the shared adder.
    assign use_sub = ctrl[ALU_SUB] | ctrl[ALU_SLT] | ctrl[ALU_SLTU];

    alu_adder u_adder (
        .a        (op_a),
        .b        (op_b),
        .invert_b (use_sub),
        .cin      (use_sub),
        .sum      (add_sum),
        .cout     (add_cout),
        .ovf      (add_ovf)
    );

    // Signed less-than: sign(A)&~sign(B) | ~(sign(A)^sign(B))&sign(diff).
    // When the signs differ the subtract overflows exactly when the diff sign
    // differs from A, so sign(diff)^ovf collapses to the same function.
    // Unsigned less-than is a borrow, i.e. no carry out of a + ~b + 1.
    assign slt_bit  = add_sum[ALU_DATA_W-1] ^ add_ovf;
    assign sltu_bit = ~add_cout;

    // AND-OR result mux: every selected op contributes, so an all-zero select
    // gives 0 and a multi-hot select gives the OR of the chosen results.
    always_comb begin
        result_next = '0;
        result_next |= {ALU_DATA_W{ctrl[ALU_ADD]}}  & add_sum;
        result_next |= {ALU_DATA_W{ctrl[ALU_SUB]}}  & add_sum;
        result_next |= {ALU_DATA_W{ctrl[ALU_SLT]}}  & {{(ALU_DATA_W-1){1'b0}}, slt_bit};
        result_next |= {ALU_DATA_W{ctrl[ALU_SLTU]}} & {{(ALU_DATA_W-1){1'b0}}, sltu_bit};
        result_next |= {ALU_DATA_W{ctrl[ALU_AND]}}  & (op_a & op_b);
        result_next |= {ALU_DATA_W{ctrl[ALU_NOR]}}  & ~(op_a | op_b);
        result_next |= {ALU_DATA_W{ctrl[ALU_OR]}}   & (op_a | op_b);
        result_next |= {ALU_DATA_W{ctrl[ALU_XOR]}}  & (op_a ^ op_b);
        result_next |= {ALU_DATA_W{ctrl[ALU_SLL]}}  & (op_b << shamt);
        result_next |= {ALU_DATA_W{ctrl[ALU_SRL]}}  & (op_b >> shamt);
        result_next |= {ALU_DATA_W{ctrl[ALU_SRA]}}  & alu_data_t'($signed(op_b) >>> shamt);
        result_next |= {ALU_DATA_W{ctrl[ALU_LUI]}}  & {op_b[15:0], 16'h0000};
    end

    // Result register; reset wins over the inputs on the same edge, which
    // also drops whatever operation was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_next;
        end
    end

    assign bus.alu_result = result_q;

`ifdef ALU_OVERFLOW_EN
    logic ovf_q;

    // Overflow only means something for add and sub; the adder already runs
    // the subtract form whenever sub is selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= (ctrl[ALU_ADD] | ctrl[ALU_SUB]) & add_ovf;
        end
    end

    assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu
// Self-checking bench for mips_alu: directed steps from the operation list,
// then randomized operations compared against an arithmetic reference model.
// Define ALU_OVERFLOW_EN on both the RTL and the bench to check overflow.
module tb_mips_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mips_alu_if bus ();

    mips_alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain integer arithmetic over the operation list.
    // Returns {overflow, result}.
    function automatic logic [32:0] ref_model(input logic [11:0] ctrl,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        longint      sa;
        longint      sb;
        longint      s;
        int          sh;
        r  = 32'd0;
        o  = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a[4:0]);
        if (ctrl[ALU_ADD]) begin
            s = sa + sb;
            r |= 32'(s);
            if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1'b1;
        end
        if (ctrl[ALU_SUB]) begin
            s = sa - sb;
            r |= 32'(s);
            if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1'b1;
        end
        if (ctrl[ALU_SLT])  r |= (sa < sb) ? 32'd1 : 32'd0;
        if (ctrl[ALU_SLTU]) r |= (a < b) ? 32'd1 : 32'd0;
        if (ctrl[ALU_AND])  r |= a & b;
        if (ctrl[ALU_NOR])  r |= ~(a | b);
        if (ctrl[ALU_OR])   r |= a | b;
        if (ctrl[ALU_XOR])  r |= a ^ b;
        if (ctrl[ALU_SLL])  r |= 32'(longint'(b) * (64'sd1 << sh));
        if (ctrl[ALU_SRL])  r |= 32'(longint'(b) / (64'sd1 << sh));
        if (ctrl[ALU_SRA])  r |= 32'(sb >>> sh);
        if (ctrl[ALU_LUI])  r |= {b[15:0], 16'h0000};
        return {o, r};
    endfunction

    // Drive one operation and let exactly one rising edge capture it.
    task automatic applyStimulus(input logic [11:0] ctrl,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
        bus.alu_control = ctrl;
        bus.alu_src1    = a;
        bus.alu_src2    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] exp_result,
                               input logic exp_ovf);
        vectors++;
        assert (bus.alu_result === exp_result)
        else begin
            miscompares++;
            $error("[TB] FAIL %s result observed=%h expected=%h",
                   tag, bus.alu_result, exp_result);
        end
`ifdef ALU_OVERFLOW_EN
        vectors++;
        assert (bus.overflow === exp_ovf)
        else begin
            miscompares++;
            $error("[TB] FAIL %s overflow observed=%b expected=%b",
                   tag, bus.overflow, exp_ovf);
        end
`else
        if (exp_ovf === 1'bx) $display("[TB] note: %s has unknown overflow expectation", tag);
`endif
    endtask

    initial begin
        logic [11:0] ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp;

        // Reset for two edges with arbitrary inputs.
        reset = 1'b1;
        applyStimulus(12'h800, 32'h7FFF_FFFF, 32'h0000_0001);
        checkOutput("reset_edge1", 32'h0, 1'b0);
        applyStimulus(12'hFFF, $urandom, $urandom);
        checkOutput("reset_edge2", 32'h0, 1'b0);

        // First edge without reset captures the current inputs.
        reset = 1'b0;
        applyStimulus(12'h800, 32'd15, 32'd20);
        checkOutput("add_15_20", 32'd35, 1'b0);
        applyStimulus(12'h800, 32'h7FFF_FFFF, 32'd1);
        checkOutput("add_ovf", 32'h8000_0000, 1'b1);
        applyStimulus(12'h400, 32'd5, 32'd7);
        checkOutput("sub_5_7", 32'hFFFF_FFFE, 1'b0);
        applyStimulus(12'h200, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_neg1_1", 32'd1, 1'b0);
        applyStimulus(12'h100, 32'hFFFF_FFFF, 32'd1);
        checkOutput("sltu_big_1", 32'd0, 1'b0);
        applyStimulus(12'h400, 32'h8000_0000, 32'd1);
        checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b1);

        // Logic ops.
        applyStimulus(12'h080, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        checkOutput("and", 32'h00F0_000F, 1'b0);
        applyStimulus(12'h020, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        checkOutput("or", 32'hFFF0_0FFF, 1'b0);
        applyStimulus(12'h010, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        checkOutput("xor", 32'hFF00_0FF0, 1'b0);
        applyStimulus(12'h040, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        checkOutput("nor", 32'h000F_F000, 1'b0);

        // Shifts use only A[4:0] (0x24 -> 4) and LUI ignores A.
        applyStimulus(12'h008, 32'h0000_0024, 32'h8000_0010);
        checkOutput("sll", 32'h0000_0100, 1'b0);
        applyStimulus(12'h004, 32'h0000_0024, 32'h8000_0010);
        checkOutput("srl", 32'h0800_0001, 1'b0);
        applyStimulus(12'h002, 32'h0000_0024, 32'h8000_0010);
        checkOutput("sra", 32'hF800_0001, 1'b0);
        applyStimulus(12'h001, 32'hDEAD_BEEF, 32'hABCD_1234);
        checkOutput("lui", 32'h1234_0000, 1'b0);

        // Zero select gives 0; multi-hot and|or gives the OR of results.
        applyStimulus(12'h000, 32'h1234_5678, 32'h9ABC_DEF0);
        checkOutput("ctrl_zero", 32'h0, 1'b0);
        applyStimulus(12'h0A0, 32'd3, 32'd5);
        checkOutput("and_or_multihot", 32'd7, 1'b0);

        // Output holds while new inputs wait for the next edge.
        bus.alu_control = 12'h800;
        bus.alu_src1    = 32'd100;
        bus.alu_src2    = 32'd1;
        #3;
        checkOutput("hold_between_edges", 32'd7, 1'b0);

        // Reset mid-stream drops the in-flight operation.
        applyStimulus(12'h800, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        checkOutput("add_before_reset", 32'hFFFF_FFFE, 1'b1);
        reset = 1'b1;
        applyStimulus(12'h800, 32'd1, 32'd2);
        checkOutput("reset_midstream", 32'h0, 1'b0);
        reset = 1'b0;

        // Randomized back-to-back operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: ctrl = 12'h000;
                1, 2: begin
                    // Multi-hot over the non-adder ops, plus at most one
                    // adder op since the adder is a single shared resource.
                    ctrl = 12'($urandom_range(1, 255));
                    if ($urandom_range(0, 1) == 1)
                        ctrl[8 + $urandom_range(0, 3)] = 1'b1;
                end
                default: ctrl = 12'(1 << $urandom_range(0, 11));
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {1'b0, {31{a[0]}}};
            if ($urandom_range(0, 3) == 0) b = {b[31], 31'($urandom_range(0, 3))};
            exp = ref_model(ctrl, a, b);
            applyStimulus(ctrl, a, b);
            checkOutput($sformatf("rand%0d_ctrl%03h", i, ctrl), exp[31:0], exp[32]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
